// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 slave memory responder with independent write and read burst FSMs
module axi_slave_mem #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter int          MEM_DEPTH  = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic                  aclk,
   input  logic                  arst,
   input  logic [3:0]            awid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [3:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic [1:0]            awlock,
   input  logic [3:0]            awcache,
   input  logic [1:0]            awprot,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [3:0]            wid,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [3:0]            bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [3:0]            arid,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [3:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   input  logic [1:0]            arlock,
   input  logic [3:0]            arcache,
   input  logic [1:0]            arprot,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [3:0]            rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [1:0] BURST_RSVD  = 2'd3;
   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
      return (a - BASE_ADDR) < WIN_BYTES;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   function automatic logic bad_burst(input logic [1:0] burst, input logic [3:0] len,
                                      input logic [2:0] size, input logic [ADDR_WIDTH-1:0] a);
      logic len_ok;
      logic aligned;
      len_ok  = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      aligned = (a & ((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1))) == '0;
      return (burst == BURST_RSVD) || (size > 3'd2) ||
             ((burst == BURST_WRAP) && (!len_ok || !aligned));
   endfunction

   // WRAP keeps the upper bits of the aligned (len+1)*(1<<size) block and wraps the low bits
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
                                                       input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] inc;
      logic [ADDR_WIDTH-1:0] mask;
      inc  = a + (ADDR_WIDTH'(1) << size);
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         BURST_FIXED: return a;
         BURST_WRAP:  return (a & ~mask) | (inc & mask);
         default:     return inc;
      endcase
   endfunction

   logic unused_sidebands;
   assign unused_sidebands = ^{awlock, awcache, awprot, arlock, arcache, arprot};

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   w_state_t w_state, w_next;

   logic [ADDR_WIDTH-1:0] w_addr;
   logic [3:0]            w_len;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;
   logic [4:0]            w_cnt;
   logic                  w_bad, w_slv, w_dec;
   logic                  aw_hs, w_hs, mem_we;

   always_ff @(posedge aclk) begin
      if (arst) w_state <= W_IDLE;
      else      w_state <= w_next;
   end

   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !arst;
            if (awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            wready = !arst;
            if (wvalid && wlast) w_next = W_RESP;
         end
         W_RESP: begin
            bvalid = !arst;
            if (bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   always_ff @(posedge aclk) begin
      if (arst) begin
         bid     <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_bad   <= 1'b0;
         w_slv   <= 1'b0;
         w_dec   <= 1'b0;
      end else if (aw_hs) begin
         bid     <= awid;
         w_addr  <= awaddr;
         w_len   <= awlen;
         w_size  <= awsize;
         w_burst <= awburst;
         w_cnt   <= '0;
         w_bad   <= bad_burst(awburst, awlen, awsize, awaddr);
         w_slv   <= 1'b0;
         w_dec   <= 1'b0;
      end else if (w_hs) begin
         w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
         w_cnt  <= w_cnt + 5'd1;
         if (!in_window(w_addr)) w_dec <= 1'b1;
         if ((wid != bid) || (wlast != (w_cnt == {1'b0, w_len}))) w_slv <= 1'b1;
      end
   end

   assign bresp  = w_dec ? RESP_DECERR : (w_slv || w_bad) ? RESP_SLVERR : RESP_OKAY;
   assign mem_we = w_hs && in_window(w_addr) && (wid == bid) && !w_bad;

   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   r_state_t r_state, r_next;

   logic [ADDR_WIDTH-1:0] r_addr, r_beat_addr;
   logic [3:0]            r_len, r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_bad, r_beat_bad;
   logic                  ar_hs, r_hs, r_advance;

   always_ff @(posedge aclk) begin
      if (arst) r_state <= R_IDLE;
      else      r_state <= r_next;
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = !arst;
            if (arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            rvalid = !arst;
            if (rready && rlast) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign ar_hs       = arvalid && arready;
   assign r_hs        = rvalid && rready;
   assign r_advance   = r_hs && !rlast;
   assign r_beat_addr = ar_hs ? araddr : next_addr(r_addr, r_len, r_size, r_burst);
   assign r_beat_bad  = ar_hs ? bad_burst(arburst, arlen, arsize, araddr) : r_bad;

   // rdata is registered from the array, so a same-edge write is seen only by the next beat
   always_ff @(posedge aclk) begin
      if (arst) begin
         rid     <= '0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
         rlast   <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_bad   <= 1'b0;
      end else if (ar_hs || r_advance) begin
         if (ar_hs) begin
            rid     <= arid;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_bad   <= r_beat_bad;
         end
         r_addr <= r_beat_addr;
         r_cnt  <= ar_hs ? 4'd0 : r_cnt + 4'd1;
         rlast  <= ar_hs ? (arlen == 4'd0) : ((r_cnt + 4'd1) == r_len);
         rdata  <= in_window(r_beat_addr) ? mem[word_idx(r_beat_addr)] : '0;
         rresp  <= !in_window(r_beat_addr) ? RESP_DECERR : r_beat_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
         rlast <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - scoreboard bench for axi_slave_mem
module tb_axi_slave_mem;

   logic        aclk = 1'b0;
   logic        arst = 1'b1;
   logic [3:0]  awid = '0, awlen = '0, awcache = '0;
   logic [31:0] awaddr = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0, awlock = '0, awprot = '0;
   logic        awvalid = 1'b0, awready;
   logic [3:0]  wid = '0, wstrb = '0;
   logic [31:0] wdata = '0;
   logic        wlast = 1'b0, wvalid = 1'b0, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready = 1'b1;
   logic [3:0]  arid = '0, arlen = '0, arcache = '0;
   logic [31:0] araddr = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0, arlock = '0, arprot = '0;
   logic        arvalid = 1'b0, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready = 1'b1;

   always #5 aclk = ~aclk;

   axi_slave_mem dut (
      .aclk(aclk), .arst(arst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        chk;
   } rbeat_t;

   int          tests = 0;
   int          fails = 0;
   logic [1:0]  bq [$];
   logic [3:0]  bidq [$];
   rbeat_t      rq [$];

   task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
      bidq.push_back(id);
      bq.push_back(resp);
   endtask

   task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic chk);
      rbeat_t b;
      b.data = d;
      b.resp = resp;
      b.last = last;
      b.chk  = chk;
      rq.push_back(b);
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      n = 0;
      @(negedge aclk);
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      while (!awready && n < 50) begin @(negedge aclk); n++; end
      if (!awready) begin tests++; fails++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
      @(posedge aclk); #1;
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [3:0] id, input logic [31:0] d0, input int nbeats,
                         input logic [3:0] strb, input int bad_beat, input int last_idx);
      for (int i = 0; i < nbeats; i++) begin
         int n;
         n = 0;
         @(negedge aclk);
         wid = (i == bad_beat) ? (id ^ 4'h1) : id;
         wdata = d0 + 32'(i); wstrb = strb; wlast = (i == last_idx); wvalid = 1'b1;
         while (!wready && n < 50) begin @(negedge aclk); n++; end
         if (!wready) begin tests++; fails++; $display("FAIL w_timeout beat %0d: wready=%b required 1", i, wready); end
         @(posedge aclk); #1;
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic collect_b();
      logic [1:0] er;
      logic [3:0] eid;
      @(negedge aclk);
      er  = bq.pop_front();
      eid = bidq.pop_front();
      tests++;
      if (bvalid !== 1'b1) begin
         fails++; $display("FAIL b_valid: bvalid=%b required 1 one cycle after last W", bvalid);
      end else begin
         if (bresp !== er) begin fails++; $display("FAIL b_resp: got %0d required %0d", bresp, er); end
         tests++;
         if (bid !== eid) begin fails++; $display("FAIL b_id: got %0d required %0d", bid, eid); end
      end
      bready = 1'b1;
      @(posedge aclk); #1;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      n = 0;
      @(negedge aclk);
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      while (!arready && n < 50) begin @(negedge aclk); n++; end
      if (!arready) begin tests++; fails++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   task automatic collect_r(input int nbeats, input logic [3:0] eid, output int gaps);
      rbeat_t e;
      gaps = 0;
      for (int i = 0; i < nbeats; i++) begin
         int w;
         w = 0;
         @(negedge aclk);
         while (!rvalid && w < 50) begin @(negedge aclk); w++; end
         gaps += w;
         e = rq.pop_front();
         tests++;
         if (!rvalid) begin
            fails++; $display("FAIL r_timeout beat %0d: rvalid=%b required 1", i, rvalid);
         end else begin
            if (e.chk && rdata !== e.data) begin
               fails++; $display("FAIL r_data beat %0d: got %h required %h", i, rdata, e.data);
            end
            tests++;
            if (rresp !== e.resp) begin fails++; $display("FAIL r_resp beat %0d: got %0d required %0d", i, rresp, e.resp); end
            tests++;
            if (rlast !== e.last) begin fails++; $display("FAIL r_last beat %0d: got %b required %b", i, rlast, e.last); end
            tests++;
            if (rid !== eid) begin fails++; $display("FAIL r_id beat %0d: got %0d required %0d", i, rid, eid); end
         end
         @(posedge aclk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      tests++;
      if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b0) begin
         fails++; $display("FAIL reset_ctrl: aw/w/ar/b/r/last=%b required 000000", {awready, wready, arready, bvalid, rvalid, rlast});
      end
      tests++;
      if ({bid, rid, rdata, bresp, rresp} !== 44'h0) begin
         fails++; $display("FAIL reset_data: bid=%0d rid=%0d rdata=%h bresp=%0d rresp=%0d required all 0", bid, rid, rdata, bresp, rresp);
      end
      arst = 1'b0;
      @(negedge aclk);
      tests++;
      if ({awready, arready} !== 2'b11) begin
         fails++; $display("FAIL reset_release: awready/arready=%b required 11", {awready, arready});
      end
   endtask

   task automatic test_incr();
      int gaps;
      push_b(4'd3, 2'd0);
      send_aw(4'd3, 32'h10, 4'd3, 3'd2, 2'd1);
      send_w(4'd3, 32'hA0, 4, 4'hF, -1, 3);
      collect_b();
      for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), 2'd0, i == 3, 1'b1);
      send_ar(4'd5, 32'h10, 4'd3, 3'd2, 2'd1);
      collect_r(4, 4'd5, gaps);
      tests++;
      if (gaps !== 0) begin fails++; $display("FAIL r_back_to_back: idle cycles %0d required 0", gaps); end
   endtask

   task automatic test_wrap();
      int gaps;
      push_b(4'd1, 2'd0);
      send_aw(4'd1, 32'h10, 4'd3, 3'd2, 2'd1);
      send_w(4'd1, 32'hB000_0000, 4, 4'hF, -1, 3);
      collect_b();
      push_r(32'hB000_0002, 2'd0, 1'b0, 1'b1);
      push_r(32'hB000_0003, 2'd0, 1'b0, 1'b1);
      push_r(32'hB000_0000, 2'd0, 1'b0, 1'b1);
      push_r(32'hB000_0001, 2'd0, 1'b1, 1'b1);
      send_ar(4'd2, 32'h18, 4'd3, 3'd2, 2'd2);
      collect_r(4, 4'd2, gaps);
      push_r(32'hB000_0001, 2'd0, 1'b0, 1'b1);
      push_r(32'hB000_0001, 2'd0, 1'b1, 1'b1);
      send_ar(4'd7, 32'h14, 4'd1, 3'd2, 2'd0);
      collect_r(2, 4'd7, gaps);
   endtask

   task automatic test_strobe();
      int gaps;
      push_b(4'd4, 2'd0);
      send_aw(4'd4, 32'h40, 4'd0, 3'd2, 2'd1);
      send_w(4'd4, 32'h1122_3344, 1, 4'hF, -1, 0);
      collect_b();
      push_b(4'd4, 2'd0);
      send_aw(4'd4, 32'h40, 4'd0, 3'd2, 2'd1);
      send_w(4'd4, 32'hAABB_CCDD, 1, 4'b0101, -1, 0);
      collect_b();
      push_r(32'h11BB_33DD, 2'd0, 1'b1, 1'b1);
      send_ar(4'd4, 32'h40, 4'd0, 3'd2, 2'd1);
      collect_r(1, 4'd4, gaps);
   endtask

   task automatic test_errors();
      int gaps;
      push_b(4'd6, 2'd0);
      send_aw(4'd6, 32'h0, 4'd0, 3'd2, 2'd1);
      send_w(4'd6, 32'h5A5A_5A5A, 1, 4'hF, -1, 0);
      collect_b();
      push_b(4'd6, 2'd3);
      send_aw(4'd6, 32'h1000, 4'd0, 3'd2, 2'd1);
      send_w(4'd6, 32'hDEAD_BEEF, 1, 4'hF, -1, 0);
      collect_b();
      push_r(32'h5A5A_5A5A, 2'd0, 1'b1, 1'b1);
      send_ar(4'd6, 32'h0, 4'd0, 3'd2, 2'd1);
      collect_r(1, 4'd6, gaps);
      push_r(32'h0, 2'd3, 1'b1, 1'b1);
      send_ar(4'd8, 32'h1000, 4'd0, 3'd2, 2'd1);
      collect_r(1, 4'd8, gaps);
      push_r(32'h0, 2'd2, 1'b0, 1'b0);
      push_r(32'h0, 2'd2, 1'b1, 1'b0);
      send_ar(4'd9, 32'h0, 4'd1, 3'd2, 2'd3);
      collect_r(2, 4'd9, gaps);
      push_b(4'd2, 2'd0);
      send_aw(4'd2, 32'h20, 4'd1, 3'd2, 2'd1);
      send_w(4'd2, 32'hC0, 2, 4'hF, -1, 1);
      collect_b();
      push_b(4'd2, 2'd2);
      send_aw(4'd2, 32'h20, 4'd1, 3'd2, 2'd1);
      send_w(4'd2, 32'hE0, 2, 4'hF, 1, 1);
      collect_b();
      push_b(4'd2, 2'd2);
      send_aw(4'd2, 32'h20, 4'd0, 3'd3, 2'd1);
      send_w(4'd2, 32'hFFFF_FFFF, 1, 4'hF, -1, 0);
      collect_b();
      push_b(4'd3, 2'd2);
      send_aw(4'd3, 32'h30, 4'd3, 3'd2, 2'd1);
      send_w(4'd3, 32'h0, 2, 4'hF, -1, 1);
      collect_b();
      push_r(32'hE0, 2'd0, 1'b0, 1'b1);
      push_r(32'hC1, 2'd0, 1'b1, 1'b1);
      send_ar(4'd1, 32'h20, 4'd1, 3'd2, 2'd1);
      collect_r(2, 4'd1, gaps);
   endtask

   task automatic test_backpressure();
      int gaps;
      bready = 1'b0;
      push_b(4'd5, 2'd0);
      send_aw(4'd5, 32'h60, 4'd3, 3'd2, 2'd1);
      send_w(4'd5, 32'hD0, 4, 4'hF, -1, 3);
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         tests++;
         if ({bvalid, awready} !== 2'b10) begin
            fails++; $display("FAIL b_stall cycle %0d: bvalid/awready=%b required 10", k, {bvalid, awready});
         end
      end
      collect_b();
      for (int i = 0; i < 4; i++) push_r(32'hD0 + 32'(i), 2'd0, i == 3, 1'b1);
      send_ar(4'd5, 32'h60, 4'd3, 3'd2, 2'd1);
      collect_r(2, 4'd5, gaps);
      @(negedge aclk);
      rready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge aclk);
         tests++;
         if ({rvalid, rlast, rdata} !== {1'b1, 1'b0, 32'hD2}) begin
            fails++; $display("FAIL r_stall cycle %0d: rvalid=%b rlast=%b rdata=%h required 1 0 000000d2", k, rvalid, rlast, rdata);
         end
      end
      @(posedge aclk); #1;
      rready = 1'b1;
      collect_r(2, 4'd5, gaps);
   endtask

   task automatic test_reset_midburst();
      int gaps;
      send_aw(4'd7, 32'h80, 4'd3, 3'd2, 2'd1);
      send_w(4'd7, 32'hF0, 2, 4'hF, -1, 99);
      @(negedge aclk);
      wid = 4'd7; wdata = 32'hF2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      arst = 1'b1;
      @(negedge aclk);
      tests++;
      if ({wready, bvalid} !== 2'b00) begin
         fails++; $display("FAIL midburst_reset: wready/bvalid=%b required 00", {wready, bvalid});
      end
      arst = 1'b0;
      wvalid = 1'b0;
      @(negedge aclk);
      tests++;
      if (awready !== 1'b1) begin fails++; $display("FAIL midburst_release: awready=%b required 1", awready); end
      push_r(32'hF0, 2'd0, 1'b0, 1'b1);
      push_r(32'hF1, 2'd0, 1'b1, 1'b1);
      send_ar(4'd7, 32'h80, 4'd1, 3'd2, 2'd1);
      collect_r(2, 4'd7, gaps);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_strobe();
      test_errors();
      test_backpressure();
      test_reset_midburst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
